// File: rtl/time_offset_calc_if.sv
`default_nettype none
// ============================================================================
//  Module      : time_offset_calc_if
//  Description : Sync-sample bus for time_offset_calc.
//                master modport : the sample source that drives the sample in
//                                 and consumes the offset write.
//                slave modport  : time_offset_calc.
//  Signals     : i_sync_valid     one-cycle strobe, sample present
//                iv_master_time   [47:7] us, [6:0] 8 ns cycles 0..124
//                iv_rx_timestamp  local time at frame receive, same format
//                iv_path_delay    [23:7] us, [6:0] cycles 0..124
//                ov_time_offset   [48] sign (0 add, 1 subtract), [47:0] magnitude
//                o_time_offset_wr one-cycle strobe qualifying ov_time_offset
//  Revision    : 1.0 - initial release
// ============================================================================
interface time_offset_calc_if;
  logic        i_sync_valid;
  logic [47:0] iv_master_time;
  logic [47:0] iv_rx_timestamp;
  logic [23:0] iv_path_delay;
  logic [48:0] ov_time_offset;
  logic        o_time_offset_wr;

  modport master (
    output i_sync_valid, iv_master_time, iv_rx_timestamp, iv_path_delay,
    input  ov_time_offset, o_time_offset_wr
  );

  modport slave (
    input  i_sync_valid, iv_master_time, iv_rx_timestamp, iv_path_delay,
    output ov_time_offset, o_time_offset_wr
  );
endinterface
`default_nettype wire

// File: rtl/time_offset_calc.sv
`default_nettype none
// ============================================================================
//  Module      : time_offset_calc
//  Description : Computes the signed offset D = (master + path_delay) - rx for
//                the time-sync block. Timestamps are mixed radix: upper field
//                in microseconds, low 7 bits in 8 ns cycles (0..124).
//                Pipeline: IDLE -> ADD -> SUB -> OUT, one cycle each, so a
//                sample strobed at cycle N is written at cycle N+3.
//  Ports       : i_clk        125 MHz system clock
//                i_rst_n      asynchronous active-low reset
//                sync_bus     time_offset_calc_if.slave (sample in, offset out)
//                o_busy       high while a sample is in flight (ADD/SUB/OUT)
//                ov_sync_cnt  offsets written, wraps
//                ov_drop_cnt  samples dropped, wraps
//  Options     : `define TIME_OFFSET_DEADBAND_EN to suppress (and count as
//                dropped) non-zero offsets below DEADBAND_CYCLES cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module time_offset_calc #(
  parameter int DEADBAND_CYCLES = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  time_offset_calc_if.slave   sync_bus,
  output logic                o_busy,
  output logic [15:0]         ov_sync_cnt,
  output logic [15:0]         ov_drop_cnt
);

  localparam logic [6:0] c_deadband = 7'(DEADBAND_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_SUB  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t      r_state;
  logic [47:0] r_master;
  logic [47:0] r_rx;
  logic [23:0] r_delay;
  logic [47:0] r_t;
  logic [48:0] r_time_offset;
  logic        r_time_offset_wr;

  // ---------------- ADD stage: T = master + path_delay ----------------------
  logic [7:0]  w_add_sum;
  logic        w_add_carry;
  logic [6:0]  w_add_lo;
  logic [40:0] w_add_hi;

  assign w_add_sum   = {1'b0, r_master[6:0]} + {1'b0, r_delay[6:0]};
  assign w_add_carry = (w_add_sum >= 8'd125);
  assign w_add_lo    = w_add_carry ? 7'(w_add_sum - 8'd125) : w_add_sum[6:0];
  // Microsecond field wraps naturally at 41 bits.
  assign w_add_hi    = r_master[47:7] + {24'd0, r_delay[23:7]} + {40'd0, w_add_carry};

  // ---------------- SUB stage: D = T - rx as sign/magnitude -----------------
  // Low fields are always < 125, so a plain compare of the packed words is the
  // same as comparing the microsecond field first and then the cycle field.
  logic        w_t_ge;
  logic [47:0] w_min;
  logic [47:0] w_sub;
  logic        w_borrow;
  logic [6:0]  w_mag_lo;
  logic [40:0] w_mag_hi;
  logic [47:0] w_mag;
  logic        w_mag_zero;
  logic        w_deadband;

  assign w_t_ge     = (r_t >= r_rx);
  assign w_min      = w_t_ge ? r_t  : r_rx;
  assign w_sub      = w_t_ge ? r_rx : r_t;
  assign w_borrow   = (w_min[6:0] < w_sub[6:0]);
  assign w_mag_lo   = 7'({1'b0, w_min[6:0]} + (w_borrow ? 8'd125 : 8'd0) - {1'b0, w_sub[6:0]});
  assign w_mag_hi   = w_min[47:7] - w_sub[47:7] - {40'd0, w_borrow};
  assign w_mag      = {w_mag_hi, w_mag_lo};
  assign w_mag_zero = (w_mag == 48'd0);

`ifdef TIME_OFFSET_DEADBAND_EN
  // Zero offsets are handled by the zero-suppress path and are not counted.
  assign w_deadband = !w_mag_zero && (w_mag_hi == 41'd0) && (w_mag_lo < c_deadband);
`else
  logic w_unused_deadband;
  assign w_unused_deadband = ^c_deadband;
  assign w_deadband        = 1'b0;
`endif

  // ---------------- Drop accounting ----------------------------------------
  logic       w_in_bad;
  logic       w_drop_sample;
  logic       w_drop_deadband;
  logic [1:0] w_drop_inc;

  assign w_in_bad        = (sync_bus.iv_master_time[6:0]  > 7'd124) ||
                           (sync_bus.iv_rx_timestamp[6:0] > 7'd124) ||
                           (sync_bus.iv_path_delay[6:0]   > 7'd124);
  // A valid is lost if it is malformed or arrives while a sample is in flight.
  assign w_drop_sample   = sync_bus.i_sync_valid && ((r_state != ST_IDLE) || w_in_bad);
  assign w_drop_deadband = (r_state == ST_SUB) && w_deadband;
  // Both sources can fire in the same SUB cycle.
  assign w_drop_inc      = {1'b0, w_drop_sample} + {1'b0, w_drop_deadband};

  // ---------------- FSM and registered outputs -----------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= ST_IDLE;
      r_master         <= 48'd0;
      r_rx             <= 48'd0;
      r_delay          <= 24'd0;
      r_t              <= 48'd0;
      r_time_offset    <= 49'd0;
      r_time_offset_wr <= 1'b0;
      o_busy           <= 1'b0;
      ov_sync_cnt      <= 16'd0;
      ov_drop_cnt      <= 16'd0;
    end else begin
      r_time_offset_wr <= 1'b0;
      ov_drop_cnt      <= ov_drop_cnt + {14'd0, w_drop_inc};
      case (r_state)
        ST_IDLE: begin
          if (sync_bus.i_sync_valid && !w_in_bad) begin
            r_master <= sync_bus.iv_master_time;
            r_rx     <= sync_bus.iv_rx_timestamp;
            r_delay  <= sync_bus.iv_path_delay;
            o_busy   <= 1'b1;
            r_state  <= ST_ADD;
          end
        end
        ST_ADD: begin
          r_t     <= {w_add_hi, w_add_lo};
          r_state <= ST_SUB;
        end
        ST_SUB: begin
          // Outputs are loaded on entry to OUT so the strobe is seen in OUT.
          if (!w_mag_zero && !w_deadband) begin
            r_time_offset    <= {~w_t_ge, w_mag};
            r_time_offset_wr <= 1'b1;
            ov_sync_cnt      <= ov_sync_cnt + 16'd1;
          end
          r_state <= ST_OUT;
        end
        ST_OUT: begin
          o_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sync_bus.ov_time_offset   = r_time_offset;
  assign sync_bus.o_time_offset_wr = r_time_offset_wr;

endmodule
`default_nettype wire

// File: tb/tb_time_offset_calc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_offset_calc
//  Description : Self-checking bench for time_offset_calc. Expected offsets are
//                queued at issue time together with the cycle they are due;
//                a monitor pops and compares on every write strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_time_offset_calc;

  localparam int DB = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] sync_cnt;
  logic [15:0] drop_cnt;

  time_offset_calc_if bus ();

  time_offset_calc #(.DEADBAND_CYCLES(DB)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .sync_bus   (bus),
    .o_busy     (busy),
    .ov_sync_cnt(sync_cnt),
    .ov_drop_cnt(drop_cnt)
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [48:0] off;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_sync = 0;
  int          exp_drop = 0;
  int          free_cyc = 0;
  logic [48:0] last_off = 49'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [47:0] tm(input logic [40:0] us, input logic [6:0] c);
    return {us, c};
  endfunction

  function automatic logic [23:0] dl(input logic [16:0] us, input logic [6:0] c);
    return {us, c};
  endfunction

  // Reference: work in absolute 8 ns cycles (125 per microsecond).
  task automatic ref_offset(input logic [47:0] m, input logic [23:0] d, input logic [47:0] rx,
                            output logic s, output logic [47:0] mag);
    logic [63:0] lo_sum, thi, tcyc, rcyc, diff;
    lo_sum = 64'(m[6:0]) + 64'(d[6:0]);
    thi    = (64'(m[47:7]) + 64'(d[23:7]) + lo_sum / 125) % (64'd1 << 41);
    tcyc   = thi * 125 + lo_sum % 125;
    rcyc   = 64'(rx[47:7]) * 125 + 64'(rx[6:0]);
    if (tcyc >= rcyc) begin s = 1'b0; diff = tcyc - rcyc; end
    else              begin s = 1'b1; diff = rcyc - tcyc; end
    mag = {41'(diff / 125), 7'(diff % 125)};
  endtask

  function automatic bit db_hit(input logic [47:0] mag);
`ifdef TIME_OFFSET_DEADBAND_EN
    return (mag != 48'd0) && (mag[47:7] == 41'd0) && (mag[6:0] < 7'(DB));
`else
    return (mag == 48'hFFFF_FFFF_FFFF) && 1'b0;
`endif
  endfunction

  // Called at a negedge; drives one valid cycle and updates the model.
  task automatic issue(input logic [47:0] m, input logic [23:0] d, input logic [47:0] rx,
                       input bit use_exp = 1'b0, input logic [48:0] hand = 49'd0);
    logic        s;
    logic [47:0] mag;
    bus.i_sync_valid    = 1'b1;
    bus.iv_master_time  = m;
    bus.iv_path_delay   = d;
    bus.iv_rx_timestamp = rx;
    if (cyc < free_cyc) exp_drop++;
    else if (m[6:0] > 7'd124 || d[6:0] > 7'd124 || rx[6:0] > 7'd124) exp_drop++;
    else begin
      free_cyc = cyc + 4;
      ref_offset(m, d, rx, s, mag);
      if (use_exp) {s, mag} = hand;
      if (mag == 48'd0) begin
      end else if (db_hit(mag)) exp_drop++;
      else begin
        exp_sync++;
        sb.push_back('{off: {s, mag}, due: cyc + 3});
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.i_sync_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic quiet_check(input string tag);
    chk({tag, "_sync_cnt"}, 64'(sync_cnt), 64'(16'(exp_sync)));
    chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(16'(exp_drop)));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_pending"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_sync_valid = 1'b0;
    sb.delete();
    exp_sync = 0;
    exp_drop = 0;
    free_cyc = 0;
    last_off = 49'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every strobe must match the head of the queue on its due cycle;
  // between strobes the offset must hold.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_time_offset_wr) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: got offset %0h at cycle %0d, expected no strobe",
                   bus.ov_time_offset, cyc);
          last_off = bus.ov_time_offset;
        end else begin
          e = sb.pop_front();
          chk("offset", 64'(bus.ov_time_offset), 64'(e.off));
          chk("latency", 64'(cyc), 64'(e.due));
          last_off = e.off;
        end
      end else begin
        chk("hold", 64'(bus.ov_time_offset), 64'(last_off));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [40:0] mh, rh;
    logic [16:0] dh;
    logic [6:0]  ml, dlo, rl;
    int          mode;

    bus.i_sync_valid    = 1'b0;
    bus.iv_master_time  = 48'd0;
    bus.iv_rx_timestamp = 48'd0;
    bus.iv_path_delay   = 24'd0;
    repeat (3) @(negedge clk);
    chk("rst_offset",   64'(bus.ov_time_offset),   64'd0);
    chk("rst_wr",       64'(bus.o_time_offset_wr), 64'd0);
    chk("rst_busy",     64'(busy),                 64'd0);
    chk("rst_sync_cnt", 64'(sync_cnt),             64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt),             64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases with hand-computed expectations.
    issue(tm(1000, 10), dl(0, 5), tm(1000, 3), 1'b1, {1'b0, tm(0, 12)});
    idle(6);
    issue(tm(5, 120), dl(0, 10), tm(4, 0), 1'b1, {1'b0, tm(2, 5)});
    idle(6);
    issue(tm(2, 0), dl(0, 0), tm(3, 100), 1'b1, {1'b1, tm(1, 100)});
    idle(6);
    quiet_check("basic");

    // Second valid one cycle after the first is dropped.
    issue(tm(1000, 10), dl(0, 5), tm(1000, 3), 1'b1, {1'b0, tm(0, 12)});
    issue(tm(50, 1), dl(0, 1), tm(10, 1));
    idle(6);
    quiet_check("busy_drop");

    // Malformed low field, then a zero-difference sample.
    issue(tm(9, 1), dl(0, 0), tm(9, 125));
    idle(6);
    quiet_check("bad_lo");
    issue(tm(7, 20), dl(0, 0), tm(7, 20));
    idle(6);
    quiet_check("zero");

    // Small offsets around the deadband threshold.
    issue(tm(0, 1), dl(0, 0), tm(0, 0));
    idle(6);
    issue(tm(0, 2), dl(0, 0), tm(0, 0), 1'b1, {1'b0, tm(0, 2)});
    idle(6);
    quiet_check("deadband");

    // Valid during OUT is dropped; the one right after is accepted.
    issue(tm(30, 60), dl(1, 70), tm(20, 10));
    idle(2);
    issue(tm(40, 0), dl(0, 0), tm(1, 0));
    issue(tm(3, 124), dl(0, 124), tm(3, 0));
    idle(6);
    quiet_check("out_edge");

    // Reset two cycles after a valid: the sample must vanish.
    issue(tm(1000, 10), dl(0, 5), tm(1000, 3));
    idle(1);
    do_reset();
    idle(6);
    quiet_check("mid_reset");

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      mode = int'($urandom_range(0, 9));
      mh   = 41'({$urandom(), $urandom()});
      if (mode == 0) mh = 41'h1FF_FFFF_FFFF - 41'($urandom_range(0, 3));
      dh   = (mode < 5) ? 17'($urandom_range(0, 3)) : 17'($urandom());
      ml   = 7'($urandom_range(0, 124));
      dlo  = 7'($urandom_range(0, 124));
      rl   = 7'($urandom_range(0, 124));
      rh   = (mode < 6) ? (mh + {24'd0, dh} + 41'($urandom_range(0, 1))) : 41'({$urandom(), $urandom()});
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 2))
          0:       ml  = 7'($urandom_range(125, 127));
          1:       dlo = 7'($urandom_range(125, 127));
          default: rl  = 7'($urandom_range(125, 127));
        endcase
      end
      issue({mh, ml}, {dh, dlo}, {rh, rl});
      idle(int'($urandom_range(0, 5)));
    end
    idle(8);
    quiet_check("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
